// File: rtl/fpu_arb_if.sv
// Signal bundle between fpu_arb and its environment: two request ports, the FPU
// issue/response handshakes, the register-file write-back port and the hazard query.
interface fpu_arb_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic [3:0]            req0_op_i;
    logic                  req0_op_mod_i;
    logic [3*DATA_W-1:0]   req0_operands_i;
    logic [TAG_W-1:0]      req0_tag_i;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic [3:0]            req1_op_i;
    logic                  req1_op_mod_i;
    logic [3*DATA_W-1:0]   req1_operands_i;
    logic [TAG_W-1:0]      req1_tag_i;

    logic                  fpu_in_valid_o;
    logic                  fpu_in_ready_i;
    logic [3:0]            fpu_op_o;
    logic                  fpu_op_mod_o;
    logic [3*DATA_W-1:0]   fpu_operands_o;
    logic [TAG_W-1:0]      fpu_tag_o;

    logic                  fpu_out_valid_i;
    logic                  fpu_out_ready_o;
    logic [DATA_W-1:0]     fpu_result_i;
    logic [TAG_W-1:0]      fpu_tag_i;

    logic                  wb_wren_o;
    logic [TAG_W-1:0]      wb_waddr_o;
    logic [DATA_W-1:0]     wb_wdata_o;

    logic [TAG_W-1:0]      hz_addr_i;
    logic                  hz_pending_o;
    logic                  busy_o;
    logic                  err_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_op_mod_i, req0_operands_i, req0_tag_i,
        output req0_ready_o,
        input  req1_valid_i, req1_op_i, req1_op_mod_i, req1_operands_i, req1_tag_i,
        output req1_ready_o,
        output fpu_in_valid_o, fpu_op_o, fpu_op_mod_o, fpu_operands_o, fpu_tag_o,
        input  fpu_in_ready_i,
        input  fpu_out_valid_i, fpu_result_i, fpu_tag_i,
        output fpu_out_ready_o,
        output wb_wren_o, wb_waddr_o, wb_wdata_o,
        input  hz_addr_i,
        output hz_pending_o, busy_o, err_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_op_mod_i, req0_operands_i, req0_tag_i,
        input  req0_ready_o,
        output req1_valid_i, req1_op_i, req1_op_mod_i, req1_operands_i, req1_tag_i,
        input  req1_ready_o,
        input  fpu_in_valid_o, fpu_op_o, fpu_op_mod_o, fpu_operands_o, fpu_tag_o,
        output fpu_in_ready_i,
        output fpu_out_valid_i, fpu_result_i, fpu_tag_i,
        input  fpu_out_ready_o,
        input  wb_wren_o, wb_waddr_o, wb_wdata_o,
        output hz_addr_i,
        input  hz_pending_o, busy_o, err_o
    );
endinterface

// File: rtl/fpu_arb.sv
// Two-port round-robin FPU issue arbiter with a per-register pending scoreboard,
// in-flight limit and a one-cycle registered register-file write-back.
module fpu_arb #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    fpu_arb_if.slave bus
);
    localparam int NREG  = 1 << TAG_W;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PAY_W = 4 + 1 + 3 * DATA_W + TAG_W;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    logic [NREG-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              rr_q, rr_d;
    logic              err_q, err_d;
    logic              wb_wren_q, wb_wren_d;
    logic [TAG_W-1:0]  wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

    logic              slot_free_s;
    logic              elig0_s, elig1_s;
    logic              winner_s;
    logic              in_valid_s;
    logic              accept_s;
    logic              resp_s;
    logic              resp_err_s;
    logic [TAG_W-1:0]  win_tag_s;
    logic [PAY_W-1:0]  pay0_s, pay1_s, fpu_pay_s;

    assign slot_free_s = (inflight_q < CNT_LIMIT);
    assign elig0_s     = bus.req0_valid_i & ~pending_q[bus.req0_tag_i] & slot_free_s;
    assign elig1_s     = bus.req1_valid_i & ~pending_q[bus.req1_tag_i] & slot_free_s;
    assign in_valid_s  = elig0_s | elig1_s;
    assign accept_s    = in_valid_s & bus.fpu_in_ready_i;
    assign resp_s      = bus.fpu_out_valid_i;
    // A response is suspicious if nothing was outstanding or its register was never issued.
    assign resp_err_s  = resp_s & ((inflight_q == CNT_ZERO) | ~pending_q[bus.fpu_tag_i]);

    assign pay0_s = {bus.req0_op_i, bus.req0_op_mod_i, bus.req0_operands_i, bus.req0_tag_i};
    assign pay1_s = {bus.req1_op_i, bus.req1_op_mod_i, bus.req1_operands_i, bus.req1_tag_i};

    // Round-robin pick between the eligible ports.
    always_comb begin
        winner_s = 1'b0;
        if (elig0_s && elig1_s) begin
            winner_s = rr_q;
        end else if (elig1_s) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Steer the winner's payload to the FPU, zeroed while nothing is eligible.
    always_comb begin
        fpu_pay_s = {PAY_W{1'b0}};
        win_tag_s = bus.req0_tag_i;
        if (!in_valid_s) begin
            fpu_pay_s = {PAY_W{1'b0}};
        end else if (winner_s) begin
            fpu_pay_s = pay1_s;
        end else begin
            fpu_pay_s = pay0_s;
        end
        if (winner_s) begin
            win_tag_s = bus.req1_tag_i;
        end else begin
            win_tag_s = bus.req0_tag_i;
        end
    end

    assign {bus.fpu_op_o, bus.fpu_op_mod_o, bus.fpu_operands_o, bus.fpu_tag_o} = fpu_pay_s;
    assign bus.fpu_in_valid_o  = in_valid_s;
    assign bus.req0_ready_o    = accept_s & ~winner_s;
    assign bus.req1_ready_o    = accept_s & winner_s;
    assign bus.fpu_out_ready_o = 1'b1;

    // Scoreboard, counter, arbitration pointer and write-back next state.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q;
        rr_d       = rr_q;
        err_d      = err_q | resp_err_s;
        wb_wren_d  = resp_s;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;

        // Clear before set so an issue to the same register in this cycle wins.
        if (resp_s) begin
            pending_d[bus.fpu_tag_i] = 1'b0;
            wb_waddr_d               = bus.fpu_tag_i;
            wb_wdata_d               = bus.fpu_result_i;
        end else begin
            wb_waddr_d = wb_waddr_q;
            wb_wdata_d = wb_wdata_q;
        end

        if (accept_s) begin
            pending_d[win_tag_s] = 1'b1;
            rr_d                 = ~winner_s;
        end else begin
            rr_d = rr_q;
        end

        case ({accept_s, resp_s})
            2'b10: begin
                if (inflight_q != CNT_SAT) begin
                    inflight_d = inflight_q + CNT_ONE;
                end else begin
                    inflight_d = inflight_q;
                end
            end
            2'b01: begin
                if (inflight_q != CNT_ZERO) begin
                    inflight_d = inflight_q - CNT_ONE;
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: begin
                inflight_d = inflight_q;
            end
        endcase
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= {NREG{1'b0}};
            inflight_q <= CNT_ZERO;
            rr_q       <= 1'b0;
            err_q      <= 1'b0;
            wb_wren_q  <= 1'b0;
            wb_waddr_q <= {TAG_W{1'b0}};
            wb_wdata_q <= {DATA_W{1'b0}};
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            rr_q       <= rr_d;
            err_q      <= err_d;
            wb_wren_q  <= wb_wren_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign bus.wb_wren_o    = wb_wren_q;
    assign bus.wb_waddr_o   = wb_waddr_q;
    assign bus.wb_wdata_o   = wb_wdata_q;
    assign bus.err_o        = err_q;
    assign bus.busy_o       = (inflight_q != CNT_ZERO) | wb_wren_q;
    assign bus.hz_pending_o = pending_q[bus.hz_addr_i] | (wb_wren_q & (wb_waddr_q == bus.hz_addr_i));
endmodule

// File: tb/tb_fpu_arb.sv
// Directed plus randomized bench for fpu_arb against a behavioural scoreboard model.
module tb_fpu_arb;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int MI = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fpu_arb_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    fpu_arb #(.DATA_W(DW), .TAG_W(TW), .MAX_INFLIGHT(MI)) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register pending set, outstanding count, turn pointer.
    bit          m_pend[32];
    int          m_infl;
    int          m_rr;
    bit          m_wren;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          m_acc0, m_acc1;
    int          fq[$];

    bit           e_valid, e_rdy0, e_rdy1, e_hz, e_busy;
    int           e_win;
    logic [105:0] e_pay;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_infl = 0; m_rr = 0; m_wren = 1'b0; m_waddr = 0; m_wdata = 32'd0; m_err = 1'b0;
        m_acc0 = 1'b0; m_acc1 = 1'b0;
    endtask

    task automatic predict();
        bit e0, e1;
        e0 = bus.req0_valid_i && !m_pend[bus.req0_tag_i] && (m_infl < MI);
        e1 = bus.req1_valid_i && !m_pend[bus.req1_tag_i] && (m_infl < MI);
        if (e0 && e1) e_win = m_rr;
        else          e_win = e1 ? 1 : 0;
        e_valid = e0 || e1;
        e_rdy0  = e_valid && (e_win == 0) && bus.fpu_in_ready_i;
        e_rdy1  = e_valid && (e_win == 1) && bus.fpu_in_ready_i;
        if (!e_valid)      e_pay = '0;
        else if (e_win==1) e_pay = {bus.req1_op_i, bus.req1_op_mod_i, bus.req1_operands_i, bus.req1_tag_i};
        else               e_pay = {bus.req0_op_i, bus.req0_op_mod_i, bus.req0_operands_i, bus.req0_tag_i};
        e_hz   = m_pend[bus.hz_addr_i] || (m_wren && (m_waddr == int'(bus.hz_addr_i)));
        e_busy = (m_infl != 0) || m_wren;
    endtask

    task automatic check_all();
        predict();
        chk("in_valid", bus.fpu_in_valid_o, e_valid);
        chk("ready0", bus.req0_ready_o, e_rdy0);
        chk("ready1", bus.req1_ready_o, e_rdy1);
        chk("payload", {bus.fpu_op_o, bus.fpu_op_mod_o, bus.fpu_operands_o, bus.fpu_tag_o}, e_pay);
        chk("out_ready", bus.fpu_out_ready_o, 1'b1);
        chk("wb_wren", bus.wb_wren_o, m_wren);
        chk("wb_waddr", bus.wb_waddr_o, m_waddr[4:0]);
        chk("wb_wdata", bus.wb_wdata_o, m_wdata);
        chk("hz_pending", bus.hz_pending_o, e_hz);
        chk("busy", bus.busy_o, e_busy);
        chk("err", bus.err_o, m_err);
    endtask

    task automatic model_edge();
        bit acc, resp;
        int t;
        predict();
        acc  = e_valid && bus.fpu_in_ready_i;
        resp = bus.fpu_out_valid_i;
        if (resp) begin
            t = int'(bus.fpu_tag_i);
            if (m_infl == 0 || !m_pend[t]) m_err = 1'b1;
            m_pend[t] = 1'b0;
        end
        if (acc) begin
            t = (e_win == 1) ? int'(bus.req1_tag_i) : int'(bus.req0_tag_i);
            m_pend[t] = 1'b1;
            m_rr = 1 - e_win;
            fq.push_back(t);
        end
        if (acc && !resp)                   m_infl++;
        else if (resp && !acc && m_infl > 0) m_infl--;
        m_wren = resp;
        if (resp) begin
            m_waddr = int'(bus.fpu_tag_i);
            m_wdata = bus.fpu_result_i;
        end
        m_acc0 = acc && (e_win == 0);
        m_acc1 = acc && (e_win == 1);
    endtask

    task automatic settle_check();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        settle_check();
        edge_step();
    endtask

    task automatic drop(input int t);
        for (int i = 0; i < fq.size(); i++) begin
            if (fq[i] == t) begin
                fq.delete(i);
                break;
            end
        end
    endtask

    task automatic set_req0(input bit v, input int t);
        bus.req0_valid_i    = v;
        bus.req0_tag_i      = t[4:0];
        bus.req0_op_i       = 4'($urandom_range(0, 15));
        bus.req0_op_mod_i   = 1'($urandom_range(0, 1));
        bus.req0_operands_i = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_req1(input bit v, input int t);
        bus.req1_valid_i    = v;
        bus.req1_tag_i      = t[4:0];
        bus.req1_op_i       = 4'($urandom_range(0, 15));
        bus.req1_op_mod_i   = 1'($urandom_range(0, 1));
        bus.req1_operands_i = {$urandom, $urandom, $urandom};
    endtask

    task automatic respond(input bit v, input int t, input logic [31:0] d);
        bus.fpu_out_valid_i = v;
        bus.fpu_tag_i       = t[4:0];
        bus.fpu_result_i    = d;
        if (v) drop(t);
    endtask

    task automatic drain();
        int t;
        set_req0(1'b0, 0);
        set_req1(1'b0, 0);
        while (fq.size() > 0) begin
            t = fq[0];
            respond(1'b1, t, $urandom);
            tick();
        end
        respond(1'b0, 0, 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_req0(1'b0, 0);
        set_req1(1'b0, 0);
        bus.fpu_in_ready_i = 1'b1;
        respond(1'b0, 0, 32'd0);
        bus.hz_addr_i = 5'd0;
        #3;
        chk("rst_wren", bus.wb_wren_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_valid", bus.fpu_in_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both ports at once: port 0 first, then port 1.
        set_req0(1'b1, 3);
        set_req1(1'b1, 7);
        settle_check();
        chk("both_port0_first", bus.req0_ready_o, 1'b1);
        chk("both_port1_waits", bus.req1_ready_o, 1'b0);
        edge_step();
        set_req0(1'b0, 0);
        settle_check();
        chk("both_port1_next", bus.req1_ready_o, 1'b1);
        edge_step();
        set_req1(1'b0, 0);
        bus.hz_addr_i = 5'd3;
        settle_check();
        chk("pending3", bus.hz_pending_o, 1'b1);
        bus.hz_addr_i = 5'd7;
        #1 chk("pending7", bus.hz_pending_o, 1'b1);
        edge_step();
        drain();

        // Write-back of register 9.
        set_req0(1'b1, 9);
        tick();
        set_req0(1'b0, 0);
        respond(1'b1, 9, 32'h3F80_0000);
        bus.hz_addr_i = 5'd9;
        tick();
        respond(1'b0, 0, 32'd0);
        settle_check();
        chk("wb9_wren", bus.wb_wren_o, 1'b1);
        chk("wb9_addr", bus.wb_waddr_o, 5'd9);
        chk("wb9_data", bus.wb_wdata_o, 32'h3F80_0000);
        chk("wb9_hz", bus.hz_pending_o, 1'b1);
        edge_step();

        // Hazard stall on register 5 until its response.
        set_req0(1'b1, 5);
        tick();
        set_req0(1'b0, 0);
        set_req1(1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("haz_stall_valid", bus.fpu_in_valid_o, 1'b0);
            chk("haz_stall_ready", bus.req1_ready_o, 1'b0);
            edge_step();
        end
        respond(1'b1, 5, $urandom);
        tick();
        respond(1'b0, 0, 32'd0);
        tick();
        if (!m_acc1) tick();
        drain();

        // In-flight limit: fifth request waits for a slot.
        for (int t = 10; t < 14; t++) begin
            set_req0(1'b1, t);
            tick();
        end
        set_req0(1'b1, 14);
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("full_stall", bus.fpu_in_valid_o, 1'b0);
            edge_step();
        end
        respond(1'b1, 10, $urandom);
        settle_check();
        chk("full_still", bus.req0_ready_o, 1'b0);
        edge_step();
        respond(1'b0, 0, 32'd0);
        settle_check();
        chk("full_grant", bus.req0_ready_o, 1'b1);
        edge_step();
        drain();

        // Issue and response in the same cycle.
        set_req0(1'b1, 4);
        tick();
        set_req0(1'b1, 2);
        respond(1'b1, 4, $urandom);
        tick();
        set_req0(1'b0, 0);
        respond(1'b0, 0, 32'd0);
        tick();
        bus.hz_addr_i = 5'd2;
        settle_check();
        chk("same_pend2", bus.hz_pending_o, 1'b1);
        bus.hz_addr_i = 5'd4;
        #1 chk("same_pend4", bus.hz_pending_o, 1'b0);
        edge_step();
        for (int t = 20; t < 23; t++) begin
            set_req0(1'b1, t);
            tick();
        end
        set_req0(1'b1, 23);
        settle_check();
        chk("same_count_full", bus.fpu_in_valid_o, 1'b0);
        edge_step();
        drain();

        // Unexpected response raises a sticky error but still writes back.
        respond(1'b1, 1, 32'h1234_5678);
        tick();
        respond(1'b0, 0, 32'd0);
        settle_check();
        chk("err_set", bus.err_o, 1'b1);
        chk("err_wb", bus.wb_wren_o, 1'b1);
        edge_step();
        tick();
        tick();
        chk("err_sticky", bus.err_o, 1'b1);

        // Randomized traffic with legal responses.
        for (int c = 0; c < 400; c++) begin
            bus.fpu_in_ready_i = ($urandom_range(0, 3) != 0);
            bus.hz_addr_i      = 5'($urandom_range(0, 31));
            if (fq.size() > 0 && $urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, fq.size() - 1);
                respond(1'b1, fq[idx], $urandom);
            end else begin
                respond(1'b0, 0, 32'd0);
            end
            tick();
            if (m_acc0 || !bus.req0_valid_i) set_req0(1'($urandom_range(0, 1)), $urandom_range(0, 31));
            if (m_acc1 || !bus.req1_valid_i) set_req1(1'($urandom_range(0, 1)), $urandom_range(0, 31));
        end

        // Keep work in flight, then reset mid-burst.
        bus.fpu_in_ready_i = 1'b1;
        respond(1'b0, 0, 32'd0);
        set_req0(1'b1, 30);
        set_req1(1'b1, 31);
        tick();
        tick();
        set_req0(1'b0, 0);
        set_req1(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_wren", bus.wb_wren_o, 1'b0);
        chk("arst_waddr", bus.wb_waddr_o, 5'd0);
        chk("arst_wdata", bus.wb_wdata_o, 32'd0);
        chk("arst_err", bus.err_o, 1'b0);
        chk("arst_busy", bus.busy_o, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Stale responses for pre-reset work now count as protocol errors.
        drain();
        chk("stale_err", bus.err_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
